// File: rtl/knn_dist_if.sv
// knn_dist streaming bus: query load, sample stream, distance result.
// master drives query/samples, slave is the distance engine.
interface knn_dist_if #(
  parameter int DW = 16
);
  logic                 clear;
  logic                 q_valid;
  logic signed [DW-1:0] q_in;
  logic                 s_valid;
  logic signed [DW-1:0] s_in;
  logic                 s_last;
  logic                 s_ready;
  logic                 dist_valid;
  logic [31:0]          dist_out;
  logic [31:0]          dist_index;
  logic                 dist_last;
  logic                 busy;

  modport master (
    output clear, q_valid, q_in,
    output s_valid, s_in, s_last,
    input  s_ready, dist_valid, dist_out,
    input  dist_index, dist_last, busy
  );

  modport slave (
    input  clear, q_valid, q_in,
    input  s_valid, s_in, s_last,
    output s_ready, dist_valid, dist_out,
    output dist_index, dist_last, busy
  );
endinterface

// File: rtl/knn_dist.sv
// Streaming squared-Euclidean distance engine feeding the top-K sorter.
// One query held, samples streamed one element per cycle, 2-stage pipe.
module knn_dist #(
  parameter int DIM = 4,
  parameter int DW  = 16
) (
  input  logic      clk,
  input  logic      rst,
  knn_dist_if.slave bus
);
  localparam int PW   = $clog2(DIM);
  localparam int SQW  = 2 * DW + 2;
  localparam int SUMW = ((SQW > 32) ? SQW : 32) + 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOADQ,
    RUN
  } state_t;

  typedef struct packed {
    logic           v;
    logic           first;
    logic           lastel;
    logic           slast;
    logic [SQW-1:0] sq;
  } s1_t;

  state_t               r_state;
  logic [PW-1:0]        r_q_ptr;
  logic [PW-1:0]        r_e_ptr;
  logic [31:0]          r_idx;
  logic signed [DW-1:0] r_q [DIM];
  s1_t                  r_s1;
  logic [31:0]          r_acc;
  logic                 r_dv;
  logic                 r_dl;
  logic [31:0]          r_dout;
  logic [31:0]          r_didx;

  logic                  w_ready;
  logic                  w_acc;
  logic signed [DW-1:0]  w_qe;
  logic signed [DW:0]    w_diff;
  logic signed [SQW-1:0] w_dx;
  logic [SQW-1:0]        w_sq;
  logic [31:0]           w_base;
  logic [SUMW-1:0]       w_sum;
  logic [31:0]           w_sat;

  assign w_ready = (r_state == RUN) && !bus.clear;
  assign w_acc   = bus.s_valid && w_ready;
  assign w_qe    = r_q[r_e_ptr];

  // Widen by one bit first so the difference never wraps.
  assign w_diff = {bus.s_in[DW-1], bus.s_in}
                - {w_qe[DW-1], w_qe};
  assign w_dx   = {{(SQW-DW-1){w_diff[DW]}}, w_diff};
  assign w_sq   = w_dx * w_dx;

  assign w_base = r_s1.first ? 32'd0 : r_acc;
  assign w_sum  = SUMW'(w_base) + SUMW'(r_s1.sq);
  // A clamped acc stays all-ones: adding more can only overflow again.
  assign w_sat  = (|w_sum[SUMW-1:32]) ? 32'hFFFF_FFFF
                                      : w_sum[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_q_ptr <= '0;
      r_e_ptr <= '0;
      r_idx   <= '0;
      for (int i = 0; i < DIM; i++) r_q[i] <= '0;
      r_s1    <= '0;
      r_acc   <= '0;
      r_dv    <= 1'b0;
      r_dl    <= 1'b0;
      r_dout  <= '0;
      r_didx  <= '0;
    end else if (bus.clear) begin
      r_state <= IDLE;
      r_q_ptr <= '0;
      r_e_ptr <= '0;
      r_idx   <= '0;
      r_s1.v  <= 1'b0;
      r_dv    <= 1'b0;
    end else begin
      r_dv <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (bus.q_valid) begin
            r_q[0]  <= bus.q_in;
            r_q_ptr <= PW'(1);
            r_state <= LOADQ;
          end
        end
        LOADQ: begin
          if (bus.q_valid) begin
            r_q[r_q_ptr] <= bus.q_in;
            if (r_q_ptr == P_LAST) begin
              r_q_ptr <= '0;
              r_state <= RUN;
            end else begin
              r_q_ptr <= r_q_ptr + PW'(1);
            end
          end
        end
        RUN: ;
        default: r_state <= IDLE;
      endcase

      r_s1.v <= w_acc;
      if (w_acc) begin
        r_s1.sq     <= w_sq;
        r_s1.first  <= (r_e_ptr == '0);
        r_s1.lastel <= (r_e_ptr == P_LAST);
        r_s1.slast  <= bus.s_last;
        r_e_ptr     <= (r_e_ptr == P_LAST) ? '0
                                           : r_e_ptr + PW'(1);
      end

      if (r_s1.v) begin
        r_acc <= w_sat;
        if (r_s1.lastel) begin
          r_dv   <= 1'b1;
          r_dout <= w_sat;
          r_didx <= r_idx;
          r_dl   <= r_s1.slast;
          if (r_s1.slast) begin
            r_idx   <= '0;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + 32'd1;
          end
        end
      end
    end
  end

  assign bus.s_ready    = w_ready;
  assign bus.dist_valid = r_dv;
  assign bus.dist_out   = r_dout;
  assign bus.dist_index = r_didx;
  assign bus.dist_last  = r_dl;
  assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_knn_dist.sv
// Directed bench for knn_dist: load, stream, saturation, gaps,
// clear and asynchronous reset, with hand-computed expectations.
module tb_knn_dist;
  localparam int DIM = 4;
  localparam int DW  = 16;

  typedef logic signed [DW-1:0] vec_t [DIM];
  typedef struct {
    logic [31:0] d;
    logic [31:0] i;
    logic        l;
    int          cyc;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  pulse_t pq[$];

  always #5 clk = ~clk;

  knn_dist_if #(.DW(DW)) vif ();

  knn_dist #(.DIM(DIM), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (vif.dist_valid === 1'b1)
      pq.push_back('{vif.dist_out, vif.dist_index,
                     vif.dist_last, cyc});

  function automatic vec_t mk(int a, int b, int c, int d);
    vec_t v;
    v[0] = DW'(a); v[1] = DW'(b);
    v[2] = DW'(c); v[3] = DW'(d);
    return v;
  endfunction

  function automatic longint model(vec_t q, vec_t s);
    longint acc = 0;
    for (int i = 0; i < DIM; i++) begin
      longint d = longint'(s[i]) - longint'(q[i]);
      acc += d * d;
      if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
    end
    return acc;
  endfunction

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_q(input vec_t q);
    for (int i = 0; i < DIM; i++) begin
      vif.q_valid = 1'b1;
      vif.q_in    = q[i];
      step();
    end
    vif.q_valid = 1'b0;
  endtask

  task automatic send(input vec_t s, input logic last,
                      input bit gaps);
    for (int i = 0; i < DIM; i++) begin
      vif.s_valid = 1'b0;
      if (gaps) step($urandom_range(0, 2));
      vif.s_valid = 1'b1;
      vif.s_in    = s[i];
      vif.s_last  = last;
      step();
    end
    vif.s_valid = 1'b0;
    vif.s_last  = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (vif.dist_valid !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b exp 0", vif.dist_valid); end
    checks++; if (vif.dist_out !== 32'd0) begin errors++; $display("FAIL rst_dout: got %0h exp 0", vif.dist_out); end
    checks++; if (vif.dist_index !== 32'd0) begin errors++; $display("FAIL rst_didx: got %0h exp 0", vif.dist_index); end
    checks++; if (vif.dist_last !== 1'b0) begin errors++; $display("FAIL rst_dlast: got %b exp 0", vif.dist_last); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", vif.busy); end
    checks++; if (vif.s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", vif.s_ready); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    pq.delete();
    load_q(mk(1, 2, 3, 4));
    checks++; if (vif.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", vif.busy); end
    checks++; if (vif.s_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b exp 1", vif.s_ready); end
    send(mk(1, 2, 3, 4), 1'b1, 1'b0);
    checks++; if (vif.dist_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b exp 0", vif.dist_valid); end
    step();
    checks++; if (vif.dist_valid !== 1'b1) begin errors++; $display("FAIL basic_lat: got %b exp 1", vif.dist_valid); end
    checks++; if (vif.dist_out !== 32'd0) begin errors++; $display("FAIL basic_dout: got %0d exp 0", vif.dist_out); end
    checks++; if (vif.dist_index !== 32'd0) begin errors++; $display("FAIL basic_didx: got %0d exp 0", vif.dist_index); end
    checks++; if (vif.dist_last !== 1'b1) begin errors++; $display("FAIL basic_dlast: got %b exp 1", vif.dist_last); end
    step();
    checks++; if (vif.dist_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b exp 0", vif.dist_valid); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b exp 0", vif.busy); end
  endtask

  task automatic test_back_to_back();
    pq.delete();
    load_q(mk(1, 2, 3, 4));
    send(mk(2, 4, 6, 8), 1'b0, 1'b0);
    send(mk(0, 0, 0, 0), 1'b1, 1'b0);
    step(3);
    checks++; if (pq.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d exp 2", pq.size()); end
    if (pq.size() == 2) begin
      checks++; if (pq[0].d !== 32'd30 || pq[0].i !== 32'd0 || pq[0].l !== 1'b0) begin errors++; $display("FAIL b2b_s0: got %0d/%0d/%b exp 30/0/0", pq[0].d, pq[0].i, pq[0].l); end
      checks++; if (pq[1].d !== 32'd30 || pq[1].i !== 32'd1 || pq[1].l !== 1'b1) begin errors++; $display("FAIL b2b_s1: got %0d/%0d/%b exp 30/1/1", pq[1].d, pq[1].i, pq[1].l); end
      checks++; if (pq[1].cyc - pq[0].cyc != DIM) begin errors++; $display("FAIL b2b_spacing: got %0d exp %0d", pq[1].cyc - pq[0].cyc, DIM); end
    end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b exp 0", vif.busy); end
    checks++; if (vif.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b exp 0", vif.s_ready); end
  endtask

  task automatic test_saturation();
    pq.delete();
    load_q(mk(-32768, -32768, -32768, -32768));
    send(mk(32767, 32767, 32767, 32767), 1'b0, 1'b0);
    send(mk(-32768, -32768, -32768, -32768), 1'b1, 1'b0);
    step(3);
    checks++; if (pq.size() != 2) begin errors++; $display("FAIL sat_count: got %0d exp 2", pq.size()); end
    if (pq.size() == 2) begin
      checks++; if (pq[0].d !== 32'hFFFF_FFFF || pq[0].i !== 32'd0) begin errors++; $display("FAIL sat_clamp: got %0h/%0d exp ffffffff/0", pq[0].d, pq[0].i); end
      checks++; if (pq[1].d !== 32'd0 || pq[1].i !== 32'd1 || pq[1].l !== 1'b1) begin errors++; $display("FAIL sat_clear: got %0h/%0d/%b exp 0/1/1", pq[1].d, pq[1].i, pq[1].l); end
    end
  endtask

  task automatic test_gaps();
    vec_t   q;
    vec_t   s [8];
    longint e [8];
    pq.delete();
    q = mk(5, -3, 100, -7);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < DIM; i++)
        s[k][i] = DW'(int'($urandom_range(0, 600)) - 300);
      e[k] = model(q, s[k]);
    end
    load_q(q);
    for (int k = 0; k < 8; k++) send(s[k], k == 7, 1'b1);
    step(4);
    checks++; if (pq.size() != 8) begin errors++; $display("FAIL gap_count: got %0d exp 8", pq.size()); end
    if (pq.size() == 8)
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (pq[k].d !== e[k][31:0] || pq[k].i !== 32'(k) || pq[k].l !== (k == 7)) begin
          errors++;
          $display("FAIL gap_s%0d: got %0d/%0d/%b exp %0d/%0d/%b", k, pq[k].d, pq[k].i, pq[k].l, e[k], k, k == 7);
        end
      end
  endtask

  task automatic test_clear();
    pq.delete();
    load_q(mk(1, 2, 3, 4));
    send(mk(0, 0, 0, 0), 1'b0, 1'b0);
    send(mk(1, 1, 1, 1), 1'b0, 1'b0);
    vif.s_valid = 1'b1;
    vif.s_in    = 16'sd9;
    step(2);
    vif.clear = 1'b1;
    #1;
    checks++; if (vif.s_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b exp 0", vif.s_ready); end
    step();
    vif.clear   = 1'b0;
    vif.s_valid = 1'b0;
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b exp 0", vif.busy); end
    step(4);
    checks++; if (pq.size() != 2) begin errors++; $display("FAIL clr_count: got %0d exp 2", pq.size()); end
    if (pq.size() == 2) begin
      checks++; if (pq[1].d !== 32'd14 || pq[1].i !== 32'd1) begin errors++; $display("FAIL clr_pre: got %0d/%0d exp 14/1", pq[1].d, pq[1].i); end
    end
    pq.delete();
    load_q(mk(1, 2, 3, 4));
    send(mk(3, 3, 3, 3), 1'b1, 1'b0);
    step(3);
    checks++; if (pq.size() != 1) begin errors++; $display("FAIL clr_after_count: got %0d exp 1", pq.size()); end
    if (pq.size() == 1) begin
      checks++; if (pq[0].d !== 32'd6 || pq[0].i !== 32'd0 || pq[0].l !== 1'b1) begin errors++; $display("FAIL clr_after: got %0d/%0d/%b exp 6/0/1", pq[0].d, pq[0].i, pq[0].l); end
    end
  endtask

  task automatic test_async_rst();
    vif.q_valid = 1'b1;
    vif.q_in    = 16'sd7;
    step();
    vif.q_in    = 16'sd8;
    step();
    vif.q_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++; if (vif.dist_out !== 32'd0) begin errors++; $display("FAIL arst_lq_dout: got %0d exp 0", vif.dist_out); end
    checks++; if (vif.dist_last !== 1'b0) begin errors++; $display("FAIL arst_lq_dlast: got %b exp 0", vif.dist_last); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL arst_lq_busy: got %b exp 0", vif.busy); end
    #1 rst = 1'b1;
    step();
    pq.delete();
    load_q(mk(10, 20, 30, 40));
    send(mk(11, 22, 33, 44), 1'b0, 1'b0);
    step(3);
    checks++; if (vif.dist_out !== 32'd30) begin errors++; $display("FAIL arst_pre: got %0d exp 30", vif.dist_out); end
    vif.s_valid = 1'b1;
    vif.s_in    = 16'sd0;
    step(2);
    vif.s_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++; if (vif.dist_out !== 32'd0) begin errors++; $display("FAIL arst_run_dout: got %0d exp 0", vif.dist_out); end
    checks++; if (vif.busy !== 1'b0 || vif.s_ready !== 1'b0) begin errors++; $display("FAIL arst_run_state: got busy %b ready %b exp 0 0", vif.busy, vif.s_ready); end
    #1 rst = 1'b1;
    step();
    pq.delete();
    load_q(mk(10, 20, 30, 40));
    send(mk(12, 20, 30, 40), 1'b1, 1'b0);
    step(3);
    checks++; if (pq.size() != 1) begin errors++; $display("FAIL arst_after_count: got %0d exp 1", pq.size()); end
    if (pq.size() == 1) begin
      checks++; if (pq[0].d !== 32'd4 || pq[0].i !== 32'd0 || pq[0].l !== 1'b1) begin errors++; $display("FAIL arst_after: got %0d/%0d/%b exp 4/0/1", pq[0].d, pq[0].i, pq[0].l); end
    end
  endtask

  initial begin
    vif.clear   = 1'b0;
    vif.q_valid = 1'b0;
    vif.q_in    = '0;
    vif.s_valid = 1'b0;
    vif.s_in    = '0;
    vif.s_last  = 1'b0;
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_gaps();
    test_clear();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/knn_dist.md
Name: knn_dist

Overview:
- Streaming squared-Euclidean distance engine, sitting directly upstream of the top-K sort/ReLU stage.
- Holds one query vector of DIM signed elements.
- Accepts sample vectors one element per cycle and emits one 32-bit distance plus a 32-bit sample index per completed sample. These drive the sorter's `in` and `index` inputs.
- `dist_last` marks the final sample of a pass, so the controller knows when to start draining the sorter.

Parameters:
- DIM, 4, elements per vector (≥2)
- DW, 16, signed element width in bits (≤16)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: return to IDLE, flush pipeline, zero sample index
- q_valid  in  1  query element strobe
- q_in  in  DW  signed query element
- s_valid  in  1  sample element valid
- s_in  in  DW  signed sample element
- s_last  in  1  qualifies the sample currently being streamed as the last of the pass; sampled with that sample's final element
- s_ready  out  1  element accepted when s_valid && s_ready
- dist_valid  out  1  one-cycle pulse, distance available
- dist_out  out  32  saturated squared distance
- dist_index  out  32  sample number, 0-based within pass
- dist_last  out  1  high with dist_valid for the last sample of the pass
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async) sets the following, from any state, mid-sample included:
  - state=IDLE; q_ptr=0; e_ptr=0; sample index=0.
  - Query registers=0; accumulator=0; pipeline valids=0.
  - All outputs 0.
- FSM states: IDLE, LOADQ, RUN.
- IDLE:
  - s_ready=0.
  - q_valid writes q_in to q[0], q_ptr=1, state→LOADQ.
- LOADQ:
  - s_ready=0.
  - Each q_valid writes q[q_ptr], q_ptr++.
  - Write of q[DIM-1] → RUN, q_ptr=0. Gaps between q_valid are allowed.
- RUN:
  - s_ready = !clear (combinational).
  - q_valid is ignored; the query is stable for the whole pass.
  - Each accepted element uses q[e_ptr]; e_ptr wraps DIM-1→0.
  - s_valid gaps stall nothing downstream; the partial sum is held.
- Datapath, 2-stage pipeline:
  - Stage 1 (registered): diff = s_in − q[e_ptr], DW+1-bit signed; sq = diff², 2DW+2-bit unsigned; tag first/last element, s_last.
  - Stage 2 (registered): first element: acc = sq; otherwise acc = acc + sq. Any result > 32'hFFFF_FFFF clamps to 32'hFFFF_FFFF and stays clamped for the rest of that sample.
  - Output: when stage 2 completes element DIM-1, register dist_out=acc_final, dist_index=index, dist_last=s_last tag, dist_valid=1 for exactly one cycle.
  - Latency: dist_valid two cycles after acceptance of element DIM-1.
  - Index increments per completed sample and wraps at 2^32.
- dist_out, dist_index and dist_last hold their last values between pulses.
- Back-to-back samples at full rate produce dist_valid every DIM cycles. There is no output backpressure: the downstream sorter accepts every pulse.
- After a dist_last sample is emitted:
  - state→IDLE; index=0.
  - The query is retained.
  - A new pass without reloading the query: q_valid in IDLE always starts a reload, so a new pass requires a reload (decided: no query reuse).
- clear, any state:
  - Next cycle: state=IDLE, e_ptr=q_ptr=0, index=0, pipeline valids cleared.
  - No dist_valid for the aborted partial sample.
  - An element presented with clear=1 is not accepted.
  - clear has priority over q_valid and s_valid.
- s_last is only meaningful on element DIM-1 and is ignored on other elements.

Test Plan:
- Reset, then load q=(1,2,3,4), stream (1,2,3,4) → dist_valid pulse exactly 2 cycles after 4th element accepted; dist_out=0, dist_index=0.
- Same query, stream (2,4,6,8) then (0,0,0,0) with s_last on the second sample → dist 30/index 0, then 30/index 1 with dist_last=1; then busy=0, s_ready=0.
- Query all −32768, sample all 32767:
  - diff=65535, sq=4294836225 per element; sum of two exceeds 2^32−1.
  - Expected: dist_out=32'hFFFF_FFFF.
  - Next sample equal to the query gives 0, proving the clamp clears per sample.
- Random s_valid gaps (50% duty), DIM=4, 8 samples vs software model → distances and indices 0..7 match; no extra or missing pulses.
- clear asserted after 2 elements of sample 3 with s_valid=1 → no dist_valid for it; busy=0 next cycle; element not accepted; after reload, first sample reports index 0.
- rst pulsed low asynchronously (mid-cycle) during LOADQ and during RUN → all outputs 0 immediately; state IDLE; a subsequent full load+stream yields correct results.
